key_scan: RTL and testbench

//   4x4 matrix keypad scanner with debounce; input-side counterpart of the 7-seg display path.

---
 rtl/key_scan.sv | 190 +++++++++++++++++++
 tb/tb_key_scan.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_scan.sv
// 4x4 matrix keypad scanner: rotates active-low column strobes, snapshots the rows,
// and debounces a single resolved key into a press pulse and a held level.
module key_scan #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned DB_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_data,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  // One spare count so a release entered at cnt=1 can still increment when DB_FRAMES=1.
  localparam int unsigned CNT_W = $clog2(DB_FRAMES + 2);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONFIRM,
    S_PRESSED,
    S_RELEASE
  } state_t;

  logic [3:0]       row_meta_q, row_meta_d;
  logic [3:0]       row_sync_q, row_sync_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_q, col_d;
  logic [15:0]      snap_q, snap_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       code_q, code_d;
  logic [3:0]       key_data_q, key_data_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  logic             tick_c;
  logic             frame_end_c;
  logic [4:0]       n_pressed_c;
  logic [3:0]       cand_code_c;
  logic             cand_valid_c;
  logic [CNT_W-1:0] cnt_inc_c;

  // Scan timing, row snapshot and candidate resolution.
  always_comb begin
    row_meta_d  = row;
    row_sync_d  = row_meta_q;
    tick_c      = (div_q == DIV_MAX);
    frame_end_c = tick_c && (col_idx_q == 2'd3);
    div_d       = tick_c ? '0 : div_q + DIV_W'(1);
    col_idx_d   = tick_c ? col_idx_q + 2'd1 : col_idx_q;
    col_d       = ~(4'b0001 << col_idx_d);

    snap_d = snap_q;
    if (tick_c) begin
      for (int unsigned c = 0; c < 4; c++) begin
        if (col_idx_q == 2'(c)) begin
          for (int unsigned r = 0; r < 4; r++) begin
            snap_d[4'(r * 4 + c)] = ~row_sync_q[r];
          end
        end
      end
    end

    n_pressed_c = '0;
    cand_code_c = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (snap_d[4'(i)]) begin
        n_pressed_c = n_pressed_c + 5'd1;
        cand_code_c = 4'(i);
      end
    end
    // Multiple pressed keys are treated like no key, rejecting ghost patterns.
    cand_valid_c = (n_pressed_c == 5'd1);
  end

  // Debounce state machine, advanced only at frame end.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    key_data_d  = key_data_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    cnt_inc_c   = cnt_q + CNT_W'(1);

    if (frame_end_c) begin
      unique case (state_q)
        S_IDLE: begin
          if (cand_valid_c) begin
            code_d = cand_code_c;
            if (CNT_W'(1) >= CNT_MAX) begin
              state_d     = S_PRESSED;
              cnt_d       = '0;
              key_data_d  = cand_code_c;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              state_d = S_CONFIRM;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        S_CONFIRM: begin
          if (cand_valid_c && (cand_code_c == code_q)) begin
            if (cnt_inc_c >= CNT_MAX) begin
              state_d     = S_PRESSED;
              cnt_d       = '0;
              key_data_d  = code_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc_c;
            end
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        S_PRESSED: begin
          if (!(cand_valid_c && (cand_code_c == code_q))) begin
            state_d = S_RELEASE;
            cnt_d   = cand_valid_c ? '0 : CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (!cand_valid_c) begin
            if (cnt_inc_c >= CNT_MAX) begin
              state_d    = S_IDLE;
              cnt_d      = '0;
              key_held_d = 1'b0;
            end else begin
              cnt_d = cnt_inc_c;
            end
          end else if (cand_code_c == code_q) begin
            state_d = S_PRESSED;
            cnt_d   = '0;
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_meta_q  <= 4'b1111;
      row_sync_q  <= 4'b1111;
      div_q       <= '0;
      col_idx_q   <= 2'd0;
      col_q       <= 4'b1110;
      snap_q      <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      code_q      <= '0;
      key_data_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      row_meta_q  <= row_meta_d;
      row_sync_q  <= row_sync_d;
      div_q       <= div_d;
      col_idx_q   <= col_idx_d;
      col_q       <= col_d;
      snap_q      <= snap_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      key_data_q  <= key_data_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col       = col_q;
  assign key_data  = key_data_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: keypad matrix model driving rows from the column strobes,
// frame-level debounce reference model, directed scenarios then random key traffic.
module tb_key_scan;

  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned DB_FRAMES = 3;
  localparam int          FRAME     = 16;
  localparam logic [15:0] K6        = 16'h0040;
  localparam logic [15:0] K69       = 16'h0240;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_data;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = '0;

  int n_assert = 0;
  int n_fail   = 0;
  int n_pulses = 0;

  // Reference model state, expressed per scan frame.
  bit   m_held;
  bit   m_pulse;
  int   m_code;
  int   m_pend_code;
  int   m_pend_n;
  bit   m_rel;
  int   m_rel_n;

  key_scan #(.SCAN_DIV(SCAN_DIV), .DB_FRAMES(DB_FRAMES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row      (row),
    .col      (col),
    .key_data (key_data),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Pressed key at (r,c) pulls row r low while column c is strobed low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cand_of(input logic [15:0] k);
    int idx;
    idx = -1;
    if ($countones(k) != 1) return -1;
    for (int i = 0; i < 16; i++) if (k[i]) idx = i;
    return idx;
  endfunction

  task automatic model_reset();
    m_held = 0; m_pulse = 0; m_code = 0;
    m_pend_code = 0; m_pend_n = 0; m_rel = 0; m_rel_n = 0;
  endtask

  task automatic model_frame(input logic [15:0] k);
    int c;
    c = cand_of(k);
    m_pulse = 0;
    if (!m_held) begin
      if (m_pend_n == 0) begin
        if (c >= 0) begin
          m_pend_code = c;
          m_pend_n = 1;
        end
      end else if (c == m_pend_code) begin
        m_pend_n++;
      end else begin
        m_pend_n = 0;
      end
      if (m_pend_n >= int'(DB_FRAMES)) begin
        m_held = 1; m_pulse = 1; m_code = m_pend_code;
        m_pend_n = 0; m_rel = 0;
      end
    end else if (!m_rel) begin
      if (c != m_code) begin
        m_rel = 1;
        m_rel_n = (c < 0) ? 1 : 0;
      end
    end else begin
      if (c < 0) begin
        m_rel_n++;
        if (m_rel_n >= int'(DB_FRAMES)) begin
          m_held = 0; m_rel = 0;
        end
      end else if (c == m_code) begin
        m_rel = 0;
      end else begin
        m_rel_n = 0;
      end
    end
  endtask

  // One full scan frame with key set k; entered and left 1 time unit after a clock edge.
  task automatic frame(input logic [15:0] k);
    logic [3:0] exp_col;
    keys = k;
    for (int i = 1; i <= FRAME; i++) begin
      @(posedge clk);
      #1;
      if (i == FRAME) model_frame(k);
      exp_col = ~(4'b0001 << ((i / 4) % 4));
      if (key_valid === 1'b1) n_pulses++;
      check("col", 32'(col), 32'(exp_col));
      check("key_valid", 32'(key_valid), 32'((i == FRAME) && m_pulse));
      check("key_held", 32'(key_held), 32'(m_held));
      check("key_data", 32'(key_data), 32'(m_code[3:0]));
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check("rst_col", 32'(col), 32'h0000000E);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_key_held", 32'(key_held), 32'h0);
    check("rst_key_data", 32'(key_data), 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    int p0;
    logic [15:0] k;
    int sel;

    // Reset held for 5 clocks.
    model_reset();
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("init_col", 32'(col), 32'h0000000E);
    check("init_key_valid", 32'(key_valid), 32'h0);
    check("init_key_held", 32'(key_held), 32'h0);
    check("init_key_data", 32'(key_data), 32'h0);
    rst_n = 1'b1;
    frame('0);
    frame('0);

    // Steady key 6: one pulse on the third frame end, then held with no repeats.
    p0 = n_pulses;
    repeat (6) frame(K6);
    check("t2_pulses", 32'(n_pulses - p0), 32'd1);
    check("t2_held", 32'(key_held), 32'h1);
    check("t2_data", 32'(key_data), 32'd6);
    repeat (3) frame('0);
    check("t2_released", 32'(key_held), 32'h0);

    // Bouncing key: two frames in, one out, never accepted.
    p0 = n_pulses;
    repeat (3) begin
      frame(K6);
      frame(K6);
      frame('0);
    end
    check("t3_pulses", 32'(n_pulses - p0), 32'd0);

    // Ghost pair 6+9 rejected; releasing 9 lets 6 through.
    p0 = n_pulses;
    repeat (4) frame(K69);
    check("t4_ghost_pulses", 32'(n_pulses - p0), 32'd0);
    repeat (3) frame(K6);
    check("t4_pulses", 32'(n_pulses - p0), 32'd1);
    check("t4_data", 32'(key_data), 32'd6);

    // Short release while pressed keeps key_held; full release clears it.
    p0 = n_pulses;
    frame('0);
    frame(K6);
    frame(K6);
    check("t5_held", 32'(key_held), 32'h1);
    check("t5_pulses", 32'(n_pulses - p0), 32'd0);
    repeat (3) frame('0);
    check("t5_released", 32'(key_held), 32'h0);

    // Reset while pressed; the still-held key is re-debounced.
    p0 = n_pulses;
    repeat (3) frame(K6);
    check("t6_held_before", 32'(key_held), 32'h1);
    pulse_reset();
    repeat (3) frame(K6);
    check("t6_pulses", 32'(n_pulses - p0), 32'd2);
    check("t6_data", 32'(key_data), 32'd6);
    repeat (3) frame('0);

    // Random key traffic, mostly repeated sets so presses get accepted.
    k = '0;
    for (int n = 0; n < 120; n++) begin
      sel = int'($urandom_range(0, 11));
      if (sel == 6) k = '0;
      else if (sel == 7 || sel == 8) k = 16'h0001 << $urandom_range(0, 15);
      else if (sel == 9) k = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      if (sel == 11 && $urandom_range(0, 3) == 0) pulse_reset();
      frame(k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
